// File: rtl/par_serial_8_1.sv
// Final 8:1 serializer stage: shifts bytes out MSB first on the bit-rate clock,
// after a comma training burst that must complete before any data is accepted.
module par_serial_8_1 #(
    parameter logic [7:0] IDLE_SYM   = 8'hBC,
    parameter int         MIN_COMMAS = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       link_up
);

    typedef enum logic {TRAIN, READY} state_t;

    state_t      state, state_nxt;
    logic [3:0]  comma_cnt, comma_nxt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic [7:0]  byte_sel;
    logic        take_data;
    logic        load;

    // bit_cnt resets to 7 so the first edge after reset is already a load edge
    assign load        = (bit_cnt == 3'd7);
    assign byte_strobe = load;

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state     <= TRAIN;
            comma_cnt <= 4'd0;
            link_up   <= 1'b0;
        end else begin
            state     <= state_nxt;
            comma_cnt <= comma_nxt;
            link_up   <= (state_nxt == READY);
        end
    end

    always_comb begin
        state_nxt = state;
        comma_nxt = comma_cnt;
        take_data = 1'b0;
        byte_sel  = IDLE_SYM;
        if (load) begin
            case (state)
                TRAIN: begin
                    comma_nxt = comma_cnt + 4'd1;
                    if (comma_cnt == 4'(MIN_COMMAS - 1))
                        state_nxt = READY;
                end
                READY: begin
                    if (valid_in) begin
                        take_data = 1'b1;
                        byte_sel  = data_in;
                    end
                end
                default: state_nxt = TRAIN;
            endcase
        end
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            bit_cnt   <= 3'd7;
            shift_reg <= 8'h00;
            data_out  <= 1'b0;
            valid_out <= 1'b0;
        end else if (load) begin
            bit_cnt   <= 3'd0;
            data_out  <= byte_sel[7];
            shift_reg <= {byte_sel[6:0], 1'b0};
            valid_out <= take_data;
        end else begin
            bit_cnt   <= bit_cnt + 3'd1;
            data_out  <= shift_reg[7];
            shift_reg <= {shift_reg[6:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_par_serial_8_1.sv
// Scoreboard bench: each byte slot pushes its 8 expected serial bits, and a
// monitor pops and checks one bit after every rising edge.
module tb_par_serial_8_1;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       data_out, valid_out, byte_strobe, link_up;

    typedef struct packed {
        logic d;
        logic v;
        logic l;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    par_serial_8_1 dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .byte_strobe(byte_strobe),
        .link_up    (link_up)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: one expected bit per rising edge while the scoreboard holds entries
    always @(posedge clk_32f) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("data_out", data_out, e.d);
            check("valid_out", valid_out, e.v);
            check("link_up", link_up, e.l);
        end
    end

    // present one byte at the next load edge and queue its expected serial image
    task automatic slot(input logic [7:0] d, input logic v,
                        input logic [7:0] exp_b, input logic exp_v, input logic exp_l);
        int t;
        t = 0;
        @(negedge clk_32f);
        while (!byte_strobe) begin
            t++;
            if (t > 16) begin
                tests++;
                fails++;
                $display("FAIL strobe_timeout: no byte_strobe within 16 cycles");
                return;
            end
            @(negedge clk_32f);
        end
        data_in  = d;
        valid_in = v;
        for (int i = 7; i >= 0; i--) q.push_back('{d: exp_b[i], v: exp_v, l: exp_l});
        @(posedge clk_32f);
        #1;
        check("strobe_after_load", byte_strobe, 1'b0);
    endtask

    task automatic check_reset_state();
        check("rst_data_out", data_out, 1'b0);
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_link_up", link_up, 1'b0);
        check("rst_byte_strobe", byte_strobe, 1'b1);
    endtask

    initial begin
        reset    = 1'b1;
        data_in  = 8'h00;
        valid_in = 1'b0;
        #2;
        check_reset_state();
        repeat (3) @(posedge clk_32f);
        #1 reset = 1'b0;

        // training with idle input, then link stays up sending commas
        for (int k = 1; k <= 6; k++) slot(8'h00, 1'b0, 8'hBC, 1'b0, k >= 4);

        // contiguous data bytes
        slot(8'hCC, 1'b1, 8'hCC, 1'b1, 1'b1);
        slot(8'hBB, 1'b1, 8'hBB, 1'b1, 1'b1);
        slot(8'hAA, 1'b1, 8'hAA, 1'b1, 1'b1);
        slot(8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1);

        // valid alternating: gaps filled with commas
        for (int k = 0; k < 2; k++) begin
            slot(8'h22, 1'b1, 8'h22, 1'b1, 1'b1);
            slot(8'h22, 1'b0, 8'hBC, 1'b0, 1'b1);
        end

        // mid-byte glitch on data_in must not be sampled
        @(negedge clk_32f) data_in = 8'h55;
        valid_in = 1'b1;
        @(negedge clk_32f) data_in = 8'h88;
        slot(8'h88, 1'b1, 8'h88, 1'b1, 1'b1);

        // a valid comma symbol is still data
        slot(8'hBC, 1'b1, 8'hBC, 1'b1, 1'b1);

        // reset in the middle of a data byte
        slot(8'hA5, 1'b1, 8'hA5, 1'b1, 1'b1);
        repeat (3) @(posedge clk_32f);
        @(negedge clk_32f);
        #2 reset = 1'b1;
        q.delete();
        #1;
        check_reset_state();
        data_in  = 8'hFF;
        valid_in = 1'b1;
        repeat (2) @(posedge clk_32f);
        #1 reset = 1'b0;

        // retraining discards valid data, then all-ones data flows
        for (int k = 1; k <= 4; k++) slot(8'hFF, 1'b1, 8'hBC, 1'b0, k >= 4);
        slot(8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1);
        slot(8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1);

        repeat (10) @(posedge clk_32f);
        #2;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
